// File: rtl/logo_memory_writer_if.sv
// Streaming pixel-write and random-read signal bundle for logo_memory_writer.
interface logo_memory_writer_if;
    logic        start;
    logic        s_valid;
    logic [1:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        frame_done;
    logic [31:0] width;
    logic [31:0] height;
    logic [1:0]  pix_value;
    logic        rd_oor;

    modport master (
        output start, s_valid, s_data, width, height,
        input  s_ready, busy, frame_done, pix_value, rd_oor
    );

    modport slave (
        input  start, s_valid, s_data, width, height,
        output s_ready, busy, frame_done, pix_value, rd_oor
    );
endinterface

// File: rtl/logo_memory_writer.sv
// Loads one frame of 2-bit pixels in raster order and serves registered random reads.
// Define LOGO_BOUNDS_CHECK_EN to range-check read indices and flag out-of-range reads.
module logo_memory_writer #(
    parameter int unsigned frame_width  = 640,
    parameter int unsigned frame_height = 480
) (
    input logic               clk,
    input logic               rst,
    logo_memory_writer_if.slave bus
);
    localparam int unsigned CW = (frame_width  > 1) ? $clog2(frame_width)  : 1;
    localparam int unsigned RW = (frame_height > 1) ? $clog2(frame_height) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic           s_ready_q;
    logic           busy_q;
    logic           frame_done_q;
    logic [1:0]     pix_q;
    logic [1:0]     mem_q [frame_height][frame_width];

    logic           accept;
    logic           last_col;
    logic           last_row;
    logic [CW-1:0]  rd_col;
    logic [RW-1:0]  rd_row;

    always_comb begin
        accept   = !rst && s_ready_q && bus.s_valid;
        last_col = (col_q == CW'(frame_width - 1));
        last_row = (row_q == RW'(frame_height - 1));
        rd_col   = bus.width[CW-1:0];
        rd_row   = bus.height[RW-1:0];
    end

    // Memory is deliberately outside the reset domain so an abandoned load keeps its pixels.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[row_q][col_q] <= bus.s_data;
        end
    end

`ifdef LOGO_BOUNDS_CHECK_EN
    logic oor_q;
    logic rd_oor_d;

    always_comb begin
        rd_oor_d = (bus.width >= 32'(frame_width)) || (bus.height >= 32'(frame_height));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            oor_q <= 1'b0;
        end else if (rd_oor_d) begin
            pix_q <= '0;
            oor_q <= 1'b1;
        end else begin
            pix_q <= mem_q[rd_row][rd_col];
            oor_q <= 1'b0;
        end
    end

    assign bus.rd_oor = oor_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= mem_q[rd_row][rd_col];
        end
    end

    assign bus.rd_oor = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= WRITE;
                        col_q     <= '0;
                        row_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                state_q      <= DONE;
                                s_ready_q    <= 1'b0;
                                frame_done_q <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pix_value  = pix_q;
endmodule

// File: doc/logo_memory_writer.md
LOGO_MEMORY_WRITER -- requirements
Module: logo_memory_writer

Interface
REQ-001 The module SHALL have parameter frame_width, default 640, meaning pixel columns per frame.
REQ-002 The module SHALL have parameter frame_height, default 480, meaning pixel rows per frame.
REQ-003 The module SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port start  input  1  single-cycle request to begin a frame load.
REQ-006 The module SHALL have port s_valid  input  1  write pixel valid.
REQ-007 The module SHALL have port s_data  input  2  write pixel value.
REQ-008 The module SHALL have port s_ready  output  1  writer accepts pixel.
REQ-009 The module SHALL have port busy  output  1  frame load in progress.
REQ-010 The module SHALL have port frame_done  output  1  one-cycle pulse after last pixel stored.
REQ-011 The module SHALL have port width  input  32  read column index.
REQ-012 The module SHALL have port height  input  32  read row index.
REQ-013 The module SHALL have port pix_value  output  2  registered read data.
REQ-014 The module SHALL have port rd_oor  output  1  registered out-of-range read flag.

Function
REQ-015 Storage SHALL be a frame_height x frame_width array of 2-bit pixels; the write address is (row, col).
REQ-016 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-017 In IDLE: s_ready=0, busy=0; start=1 -> WRITE with col=0, row=0.
REQ-018 In WRITE: s_ready=1, busy=1; a pixel SHALL be stored only on a cycle with s_valid=1 and s_ready=1.
REQ-019 Each accepted pixel: col++, and at col=frame_width-1 col wraps to 0 and row++.
REQ-020 Acceptance at (frame_height-1, frame_width-1) SHALL store the pixel, move to DONE and drop s_ready on the next cycle.
REQ-021 In DONE: frame_done=1, s_ready=0, busy=1 for exactly one cycle, then IDLE.
REQ-022 start SHALL be ignored in WRITE and DONE; s_valid SHALL be ignored while s_ready=0.
REQ-023 The read SHALL have 1-cycle latency: pix_value on cycle n+1 = memory[height][width] sampled at cycle n, in every state.
REQ-024 A read and a write to the same address on one cycle SHALL return the old (pre-write) value.
REQ-025 Indices SHALL be compared as unsigned 32-bit; col/row counters SHALL be sized to hold frame_width-1 / frame_height-1.

Reset
REQ-026 rst=1 on a clock edge SHALL force IDLE, col=0, row=0, s_ready=0, busy=0, frame_done=0, pix_value=2'b00, rd_oor=0, and SHALL take priority over start and s_valid.
REQ-027 Reset SHALL NOT clear memory contents; reset mid-WRITE SHALL abandon the load, pixels already stored SHALL be kept, and the next start SHALL restart at (0,0).

Configuration
REQ-028 With LOGO_BOUNDS_CHECK_EN defined: width>=frame_width or height>=frame_height SHALL give pix_value=2'b00 and rd_oor=1 the next cycle, with memory not indexed.
REQ-029 Without LOGO_BOUNDS_CHECK_EN: rd_oor SHALL be tied 0, no range compare SHALL exist, and out-of-range read data is unspecified.

Verification (frame_width=4, frame_height=3)
REQ-030 Full load: start then 12 pixels with s_valid held high, values i%4 -> s_ready high for 12 cycles, frame_done pulses once, reading (2,3) returns 2'b11.
REQ-031 Backpressure-free gaps: s_valid toggled 1/0 -> exactly 12 writes, row increments after each col=3 write, frame_done only after the 12th.
REQ-032 Same-cycle read/write at (0,0) with old=2'b01, new=2'b10 -> pix_value=2'b01, then 2'b10 on a repeat read.
REQ-033 rst asserted after 5 pixels -> busy=0 and s_ready=0 next cycle; new load overwrites from (0,0); (1,0) keeps its first-load value until rewritten.
REQ-034 With LOGO_BOUNDS_CHECK_EN: read width=4, height=0 -> pix_value=2'b00, rd_oor=1; read (2,3) -> rd_oor=0.
REQ-035 start pulsed during WRITE and s_valid during IDLE -> no counter change, no write.
